// File: rtl/engine_dispatcher.sv
// Command dispatcher: queues host commands in a FIFO and hands LINE/CIRCLE payloads to their engines.
// Latency: 3 edges from push to rts_out with an empty, idle block. Backpressure: cmd_rtr_out low when the FIFO is full.
// Optional ENGINE_DISPATCH_STATS_EN adds saturating per-engine dispatch counters (tied to 0 otherwise).
module engine_dispatcher #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [63:0] cmd_data,
    input  logic        cmd_rts_in,
    output logic        cmd_rtr_out,
    output logic [59:0] eng_payload,
    output logic        line_rts_out,
    input  logic        line_rtr_in,
    input  logic        line_busy_in,
    output logic        circle_rts_out,
    input  logic        circle_rtr_in,
    input  logic        circle_busy_in,
    output logic        busy_out,
    output logic        err_out,
    output logic [15:0] line_count_out,
    output logic [15:0] circle_count_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LINE   = 4'd1;
    localparam logic [3:0] OP_CIRCLE = 4'd2;
    localparam logic [3:0] OP_FENCE  = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_ISSUE,
        S_FENCE_WAIT
    } state_t;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    state_t        state_q;
    logic          line_rts_q, circle_rts_q, err_q;

    logic          push, pop, not_empty;
    logic [63:0]   head;
    logic [3:0]    head_op;
    logic          line_xfer, circle_xfer, fence_clear;

    assign not_empty   = (count_q != '0);
    assign cmd_rtr_out = (count_q < DEPTH_C);
    assign push        = cmd_rts_in & cmd_rtr_out;
    assign head        = mem_q[rd_ptr_q];
    assign head_op     = head[63:60];
    assign eng_payload = not_empty ? head[59:0] : 60'd0;

    assign line_xfer   = line_rts_q & line_rtr_in;
    assign circle_xfer = circle_rts_q & circle_rtr_in;
    assign fence_clear = ~line_busy_in & ~circle_busy_in & ~line_rts_q & ~circle_rts_q;

    // The head leaves the FIFO only once the FSM has finished with it.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            S_DECODE:     pop = (head_op == OP_NOP) || (head_op > OP_FENCE);
            S_ISSUE:      pop = line_xfer | circle_xfer;
            S_FENCE_WAIT: pop = fence_clear;
            default:      pop = 1'b0;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= S_IDLE;
            line_rts_q   <= 1'b0;
            circle_rts_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (not_empty) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    case (head_op)
                        OP_NOP:    state_q <= S_IDLE;
                        OP_LINE: begin
                            state_q    <= S_ISSUE;
                            line_rts_q <= 1'b1;
                        end
                        OP_CIRCLE: begin
                            state_q      <= S_ISSUE;
                            circle_rts_q <= 1'b1;
                        end
                        OP_FENCE:  state_q <= S_FENCE_WAIT;
                        default: begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                        end
                    endcase
                end
                S_ISSUE: begin
                    if (line_xfer || circle_xfer) begin
                        state_q      <= S_IDLE;
                        line_rts_q   <= 1'b0;
                        circle_rts_q <= 1'b0;
                    end
                end
                S_FENCE_WAIT: begin
                    if (fence_clear) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign line_rts_out   = line_rts_q;
    assign circle_rts_out = circle_rts_q;
    assign err_out        = err_q;
    assign busy_out       = not_empty | (state_q != S_IDLE) | line_busy_in | circle_busy_in;

`ifdef ENGINE_DISPATCH_STATS_EN
    logic [15:0] line_cnt_q, circle_cnt_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            line_cnt_q   <= '0;
            circle_cnt_q <= '0;
        end else begin
            if (line_xfer && line_cnt_q != 16'hFFFF)     line_cnt_q   <= line_cnt_q + 1'b1;
            if (circle_xfer && circle_cnt_q != 16'hFFFF) circle_cnt_q <= circle_cnt_q + 1'b1;
        end
    end

    assign line_count_out   = line_cnt_q;
    assign circle_count_out = circle_cnt_q;
`else
    assign line_count_out   = 16'd0;
    assign circle_count_out = 16'd0;
`endif

endmodule

// File: tb/tb_engine_dispatcher.sv
// Bench for engine_dispatcher: directed scenarios plus a randomized run checked against a queue-based model.
module tb_engine_dispatcher;

`ifdef ENGINE_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LINE   = 4'd1;
    localparam logic [3:0] OP_CIRCLE = 4'd2;
    localparam logic [3:0] OP_FENCE  = 4'd3;

    logic        clk, rst_;
    logic [63:0] cmd_data;
    logic        cmd_rts_in, cmd_rtr_out;
    logic [59:0] eng_payload;
    logic        line_rts_out, line_rtr_in, line_busy_in;
    logic        circle_rts_out, circle_rtr_in, circle_busy_in;
    logic        busy_out, err_out;
    logic [15:0] line_count_out, circle_count_out;

    engine_dispatcher #(.DEPTH(4)) dut (
        .clk             (clk),
        .rst_            (rst_),
        .cmd_data        (cmd_data),
        .cmd_rts_in      (cmd_rts_in),
        .cmd_rtr_out     (cmd_rtr_out),
        .eng_payload     (eng_payload),
        .line_rts_out    (line_rts_out),
        .line_rtr_in     (line_rtr_in),
        .line_busy_in    (line_busy_in),
        .circle_rts_out  (circle_rts_out),
        .circle_rtr_in   (circle_rtr_in),
        .circle_busy_in  (circle_busy_in),
        .busy_out        (busy_out),
        .err_out         (err_out),
        .line_count_out  (line_count_out),
        .circle_count_out(circle_count_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: accepted LINE/CIRCLE commands in arrival order, illegal-opcode flag, transfer tallies.
    logic [63:0] exp_q[$];
    bit          model_err;
    int          model_lc, model_cc;
    int          line_xfers = 0;
    int          circle_xfers = 0;
    bit          hold_l, hold_c;
    logic [59:0] hold_pay;

    always @(negedge clk) begin
        logic [63:0] e;
        logic [3:0]  op;
        if (!rst_) begin
            exp_q.delete();
            model_err = 1'b0;
            model_lc  = 0;
            model_cc  = 0;
            hold_l    = 1'b0;
            hold_c    = 1'b0;
        end else begin
            chk("rts_mutex", 64'(line_rts_out & circle_rts_out), 64'd0);
            if (hold_l) begin
                chk("hold_line_rts", 64'(line_rts_out), 64'd1);
                chk("hold_line_pay", 64'(eng_payload), 64'(hold_pay));
            end
            if (hold_c) begin
                chk("hold_circle_rts", 64'(circle_rts_out), 64'd1);
                chk("hold_circle_pay", 64'(eng_payload), 64'(hold_pay));
            end
            if (cmd_rts_in && cmd_rtr_out) begin
                op = cmd_data[63:60];
                if (op == OP_LINE || op == OP_CIRCLE) exp_q.push_back(cmd_data);
                else if (op > OP_FENCE) model_err = 1'b1;
            end
            if (line_rts_out && line_rtr_in) begin
                line_xfers++;
                model_lc++;
                if (exp_q.size() == 0) begin
                    chk("line_xfer_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("line_xfer_op", 64'(OP_LINE), 64'(e[63:60]));
                    chk("line_xfer_pay", 64'(eng_payload), 64'(e[59:0]));
                end
            end
            if (circle_rts_out && circle_rtr_in) begin
                circle_xfers++;
                model_cc++;
                if (exp_q.size() == 0) begin
                    chk("circle_xfer_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("circle_xfer_op", 64'(OP_CIRCLE), 64'(e[63:60]));
                    chk("circle_xfer_pay", 64'(eng_payload), 64'(e[59:0]));
                end
            end
            hold_l   = line_rts_out & ~line_rtr_in;
            hold_c   = circle_rts_out & ~circle_rtr_in;
            hold_pay = eng_payload;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [59:0] pay);
        cmd_data   = {op, pay};
        cmd_rts_in = 1'b1;
        step();
        cmd_rts_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_out && n < 500) begin
            step();
            n++;
        end
        chk(tag, 64'(busy_out), 64'd0);
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        step();
        step();
        rst_ = 1'b1;
    endtask

    initial begin
        int l0, c0, n;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, c0, n;
        logic [3:0] op;
        rst_ = 1'b0;
        cmd_data = '0; cmd_rts_in = 1'b0;
        line_rtr_in = 1'b0; line_busy_in = 1'b1;
        circle_rtr_in = 1'b0; circle_busy_in = 1'b0;
        #3;
        // Reset state, with busy_out following the engines' busy lines.
        chk("rst_busy_engine", 64'(busy_out), 64'd1);
        line_busy_in = 1'b0;
        #1;
        chk("rst_busy_idle", 64'(busy_out), 64'd0);
        chk("rst_rtr", 64'(cmd_rtr_out), 64'd1);
        chk("rst_payload", 64'(eng_payload), 64'd0);
        chk("rst_rts", 64'({line_rts_out, circle_rts_out}), 64'd0);
        chk("rst_err", 64'(err_out), 64'd0);
        chk("rst_counts", 64'({line_count_out, circle_count_out}), 64'd0);
        step();
        rst_ = 1'b1;

        // Minimum latency: push, DECODE, ISSUE, then transfer.
        line_rtr_in = 1'b1;
        push_cmd(OP_LINE, 60'h123);
        chk("lat_edge1", 64'(line_rts_out), 64'd0);
        step();
        chk("lat_edge2", 64'(line_rts_out), 64'd0);
        step();
        chk("lat_edge3_rts", 64'(line_rts_out), 64'd1);
        chk("lat_edge3_pay", 64'(eng_payload), 64'h123);
        step();
        chk("lat_edge4_rts", 64'(line_rts_out), 64'd0);
        chk("lat_edge4_busy", 64'(busy_out), 64'd0);

        // Full FIFO: the fifth push is refused and only four are dispatched.
        line_rtr_in = 1'b0;
        cmd_rts_in  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cmd_data = {OP_LINE, 60'(32'h200 + i)};
            step();
            chk("full_rtr", 64'(cmd_rtr_out), (i < 4) ? 64'd1 : 64'd0);
        end
        cmd_rts_in = 1'b0;
        l0 = line_xfers;
        repeat (3) step();
        chk("full_rtr_held", 64'(cmd_rtr_out), 64'd0);
        line_rtr_in = 1'b1;
        wait_idle("full_drain");
        chk("full_count4", 64'(line_xfers - l0), 64'd4);

        // FENCE holds the following LINE until the circle engine goes idle.
        circle_rtr_in = 1'b1;
        cmd_rts_in = 1'b1;
        cmd_data = {OP_CIRCLE, 60'h77}; step();
        cmd_data = {OP_FENCE, 60'h0};   step();
        cmd_data = {OP_LINE, 60'h88};   step();
        cmd_rts_in = 1'b0;
        n = 0;
        while (!circle_rts_out && n < 20) begin step(); n++; end
        chk("fence_circle_rts", 64'(circle_rts_out), 64'd1);
        step();
        circle_busy_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("fence_hold", 64'(line_rts_out), 64'd0);
            step();
        end
        circle_busy_in = 1'b0;
        n = 0;
        while (!line_rts_out && n < 20) begin step(); n++; end
        chk("fence_release", 64'(line_rts_out), 64'd1);
        wait_idle("fence_drain");

        // Illegal opcode sets the sticky error and is dropped.
        push_cmd(4'hA, 60'h55);
        repeat (4) step();
        chk("illegal_err", 64'(err_out), 64'd1);
        l0 = line_xfers;
        push_cmd(OP_LINE, 60'h99);
        wait_idle("illegal_drain");
        chk("illegal_next_line", 64'(line_xfers - l0), 64'd1);
        chk("illegal_err_sticky", 64'(err_out), 64'd1);

        // Reset mid-ISSUE drops rts and the queued commands.
        circle_rtr_in = 1'b0;
        cmd_rts_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_data = {OP_CIRCLE, 60'(32'h300 + i)};
            step();
        end
        cmd_rts_in = 1'b0;
        chk("rstmid_pre_rts", 64'(circle_rts_out), 64'd1);
        chk("rstmid_pre_full", 64'(cmd_rtr_out), 64'd0);
        rst_ = 1'b0;
        #1;
        chk("rstmid_rts", 64'(circle_rts_out), 64'd0);
        chk("rstmid_rtr", 64'(cmd_rtr_out), 64'd1);
        chk("rstmid_payload", 64'(eng_payload), 64'd0);
        chk("rstmid_busy", 64'(busy_out), 64'd0);
        chk("rstmid_err", 64'(err_out), 64'd0);
        step();
        rst_ = 1'b1;
        circle_rtr_in = 1'b1;
        c0 = circle_xfers;
        repeat (20) step();
        chk("rstmid_no_dispatch", 64'(circle_xfers - c0), 64'd0);
        chk("rstmid_idle", 64'(busy_out), 64'd0);

        // Dispatch counters.
        chk("cnt_zero", 64'({line_count_out, circle_count_out}), 64'd0);
        line_rtr_in = 1'b1;
        push_cmd(OP_LINE, 60'h1);
        push_cmd(OP_CIRCLE, 60'h2);
        push_cmd(OP_LINE, 60'h3);
        push_cmd(OP_CIRCLE, 60'h4);
        push_cmd(OP_LINE, 60'h5);
        wait_idle("cnt_drain");
        chk("cnt_line", 64'(line_count_out), STATS ? 64'd3 : 64'd0);
        chk("cnt_circle", 64'(circle_count_out), STATS ? 64'd2 : 64'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            n = $urandom_range(0, 9);
            if (n < 4)       op = OP_LINE;
            else if (n < 7)  op = OP_CIRCLE;
            else if (n == 7) op = OP_NOP;
            else if (n == 8) op = OP_FENCE;
            else             op = 4'($urandom_range(4, 15));
            cmd_data       = {op, 28'($urandom), $urandom};
            cmd_rts_in     = $urandom_range(0, 1) == 1;
            line_rtr_in    = $urandom_range(0, 1) == 1;
            circle_rtr_in  = $urandom_range(0, 1) == 1;
            line_busy_in   = $urandom_range(0, 4) == 0;
            circle_busy_in = $urandom_range(0, 4) == 0;
            step();
        end
        cmd_rts_in = 1'b0;
        line_busy_in = 1'b0; circle_busy_in = 1'b0;
        line_rtr_in = 1'b1;  circle_rtr_in = 1'b1;
        wait_idle("rand_drain");
        step();
        chk("rand_pending", 64'(exp_q.size()), 64'd0);
        chk("rand_err", 64'(err_out), 64'(model_err));
        chk("rand_cnt_line", 64'(line_count_out), STATS ? 64'(model_lc) : 64'd0);
        chk("rand_cnt_circle", 64'(circle_count_out), STATS ? 64'(model_cc) : 64'd0);
        chk("rand_rtr", 64'(cmd_rtr_out), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
